// File: rtl/uart_tx_framed.sv
// uart_tx_framed: framed UART transmitter (start, DATA_BITS LSB first,
// optional odd/even parity, 1..2 stop bits). One bit period is DIV clocks,
// DIV = (CLK + BAUD/2) / BAUD. Define UART_TX_FRAMED_BREAK_EN to add the
// break_req port and the BREAK state (line held low while requested).
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line marking (pin=1), data_ready=1, waiting for a word
// S_START  | start bit (pin=0)
// S_DATA   | data bits, LSB first, shifted out of shift_reg
// S_PARITY | parity bit (only reached when PARITY != 0)
// S_STOP   | stop bits (pin=1), STOP_BITS bit periods
// S_BREAK  | line break, pin=0 while break_req=1 (macro builds only)
module uart_tx_framed #(
  parameter int CLK       = 51_800_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 pin,
  output logic                 data_ready,
  input  logic                 data_valid,
  input  logic [DATA_BITS-1:0] data_word
`ifdef UART_TX_FRAMED_BREAK_EN
  ,
  input  logic                 break_req
`endif
);

  localparam int DIV = (CLK + BAUD / 2) / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1    = CW'(DIV - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || DIV < 2) begin : g_bad_params
    $error("uart_tx_framed: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_FRAMED_BREAK_EN
    ,
    S_BREAK
`endif
  } state_t;

  state_t                state, state_next;
  logic [CW-1:0]         baud_cnt, baud_next;
  logic [3:0]            bit_cnt, bit_next;
  logic [DATA_BITS-1:0]  shift_reg, shift_next;
  logic                  par_bit, par_next;
  logic                  pin_next;
  logic                  ready_next;
  logic                  tick;

  // State and all registered outputs; reset aborts any frame immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pin        <= 1'b1;
      data_ready <= 1'b1;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
    end else begin
      state      <= state_next;
      pin        <= pin_next;
      data_ready <= ready_next;
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
      shift_reg  <= shift_next;
      par_bit    <= par_next;
    end
  end

  // Next-state logic; pin only changes when the baud down-counter hits 0.
  always_comb begin
    state_next = state;
    pin_next   = pin;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    shift_next = shift_reg;
    par_next   = par_bit;
    tick       = (baud_cnt == '0);

    if (state != S_IDLE && !tick) baud_next = baud_cnt - 1'b1;

    case (state)
      S_IDLE: begin
        pin_next = 1'b1;
`ifdef UART_TX_FRAMED_BREAK_EN
        if (break_req) begin
          state_next = S_BREAK;
          pin_next   = 1'b0;
        end else
`endif
        if (data_ready && data_valid) begin
          state_next = S_START;
          pin_next   = 1'b0;
          shift_next = data_word;
          // Odd parity inverts the XOR so the total count of ones is odd.
          par_next   = (^data_word) ^ (PARITY == 1);
          baud_next  = DIV_M1;
          bit_next   = '0;
        end
      end
      S_START: begin
        if (tick) begin
          state_next = S_DATA;
          pin_next   = shift_reg[0];
          shift_next = shift_reg >> 1;
          bit_next   = '0;
          baud_next  = DIV_M1;
        end
      end
      S_DATA: begin
        if (tick) begin
          baud_next = DIV_M1;
          if (bit_cnt == LAST_DATA) begin
            if (PARITY != 0) begin
              state_next = S_PARITY;
              pin_next   = par_bit;
            end else begin
              state_next = S_STOP;
              pin_next   = 1'b1;
              bit_next   = '0;
            end
          end else begin
            bit_next   = bit_cnt + 1'b1;
            pin_next   = shift_reg[0];
            shift_next = shift_reg >> 1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_next = S_STOP;
          pin_next   = 1'b1;
          bit_next   = '0;
          baud_next  = DIV_M1;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bit_cnt == LAST_STOP) begin
            state_next = S_IDLE;
            pin_next   = 1'b1;
          end else begin
            bit_next  = bit_cnt + 1'b1;
            baud_next = DIV_M1;
          end
        end
      end
`ifdef UART_TX_FRAMED_BREAK_EN
      S_BREAK: begin
        pin_next = 1'b0;
        if (!break_req) begin
          state_next = S_IDLE;
          pin_next   = 1'b1;
        end
      end
`endif
      default: begin
        state_next = S_IDLE;
        pin_next   = 1'b1;
      end
    endcase

    ready_next = (state_next == S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed: three instances (8N1, 7E2, 8O1) at
// DIV=8; frames are compared bit-by-bit every clock against hand-built
// bit patterns (bit i of the pattern = i-th bit on the line).
module tb_uart_tx_framed;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] valid;
  logic [7:0] words [3];
  logic       pin0, pin1, pin2;
  logic       rdy0, rdy1, rdy2;
  logic [2:0] pins, readys;
`ifdef UART_TX_FRAMED_BREAK_EN
  logic       brk;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  assign pins   = {pin2, pin1, pin0};
  assign readys = {rdy2, rdy1, rdy0};

  uart_tx_framed #(.CLK(8), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .pin(pin0), .data_ready(rdy0),
    .data_valid(valid[0]), .data_word(words[0])
`ifdef UART_TX_FRAMED_BREAK_EN
    , .break_req(brk)
`endif
  );

  uart_tx_framed #(.CLK(8), .BAUD(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
    .clk(clk), .reset(reset), .pin(pin1), .data_ready(rdy1),
    .data_valid(valid[1]), .data_word(words[1][6:0])
`ifdef UART_TX_FRAMED_BREAK_EN
    , .break_req(1'b0)
`endif
  );

  uart_tx_framed #(.CLK(8), .BAUD(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .reset(reset), .pin(pin2), .data_ready(rdy2),
    .data_valid(valid[2]), .data_word(words[2])
`ifdef UART_TX_FRAMED_BREAK_EN
    , .break_req(1'b0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Offer a word at a negedge; returns just after the accepting edge E0.
  task automatic send(input int sel, input logic [7:0] w);
    @(negedge clk);
    chk("ready_before_send", 32'(readys[sel]), 1);
    valid[sel] = 1'b1;
    words[sel] = w;
    @(posedge clk);
  endtask

  // Check every clock of an n-bit frame starting at E0, then the idle clock.
  // nv/nw are driven at the first negedge (lets a bench keep valid high).
  task automatic check_frame(input int sel, input logic [15:0] bits, input int n,
                             input logic nv, input logic [7:0] nw);
    for (int j = 1; j <= n * 8; j++) begin
      @(negedge clk);
      chk("frame_pin", 32'(pins[sel]), 32'(bits[(j - 1) / 8]));
      chk("busy_ready", 32'(readys[sel]), 0);
      if (j == 1) begin
        valid[sel] = nv;
        words[sel] = nw;
      end
    end
    @(negedge clk);
    chk("ready_at_end", 32'(readys[sel]), 1);
    chk("idle_pin", 32'(pins[sel]), 1);
  endtask

  initial begin
    reset = 1'b1;
    valid = 3'b000;
    for (int i = 0; i < 3; i++) words[i] = 8'h00;
`ifdef UART_TX_FRAMED_BREAK_EN
    brk = 1'b0;
`endif
    #1;
    chk("reset_pin", 32'(pins), 32'h7);
    chk("reset_ready", 32'(readys), 32'h7);
    @(negedge clk);
    reset = 1'b0;

    // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1 ; ready back at E0+80
    send(0, 8'h55);
    check_frame(0, 16'h02AA, 10, 1'b0, 8'h00);

    // 7E2 0x41: 0,1000001,parity 0,1,1 ; ready back at E0+88
    send(1, 8'h41);
    check_frame(1, 16'h0682, 11, 1'b0, 8'h00);

    // 8O1 0x00 -> parity 1 ; 0x01 -> parity 0
    send(2, 8'h00);
    check_frame(2, 16'h0600, 11, 1'b0, 8'h00);
    send(2, 8'h01);
    check_frame(2, 16'h0402, 11, 1'b0, 8'h00);

    // back-to-back with valid held: 0xA5 then 0x3C, one idle clock between
    send(0, 8'hA5);
    check_frame(0, 16'h034A, 10, 1'b1, 8'h3C);
    check_frame(0, 16'h0278, 10, 1'b0, 8'h00);

    // reset at clock 30 of a 0x00 frame, then 0xFF on the first edge after release
    send(0, 8'h00);
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (j == 1) valid[0] = 1'b0;
    end
    chk("midframe_pin", 32'(pin0), 0);
    chk("midframe_ready", 32'(rdy0), 0);
    reset = 1'b1;
    #1;
    chk("abort_pin", 32'(pins), 32'h7);
    chk("abort_ready", 32'(readys), 32'h7);
    @(negedge clk);
    reset = 1'b0;
    valid[0] = 1'b1;
    words[0] = 8'hFF;
    @(posedge clk);
    check_frame(0, 16'h03FE, 10, 1'b0, 8'h00);

`ifdef UART_TX_FRAMED_BREAK_EN
    // break_req + data_valid together for 20 clocks: line low, no byte sent
    @(negedge clk);
    brk = 1'b1;
    valid[0] = 1'b1;
    words[0] = 8'h5A;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      chk("break_pin", 32'(pin0), 0);
      chk("break_ready", 32'(rdy0), 0);
      if (j == 20) begin
        brk = 1'b0;
        valid[0] = 1'b0;
      end
    end
    @(negedge clk);
    chk("break_exit_ready", 32'(rdy0), 1);
    chk("break_exit_pin", 32'(pin0), 1);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      chk("post_break_pin", 32'(pin0), 1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_tx_framed.md
UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
REQ-001 SHALL have parameter CLK, default 51_800_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal values 5..9.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1..2.
REQ-006 SHALL have port clk, input, 1 bit, meaning the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, meaning reset; asynchronous and active-high.
REQ-008 SHALL have port pin, output, 1 bit, meaning serial line; idle/mark = 1.
REQ-009 SHALL have port data_ready, output, 1 bit, meaning the block can accept a word.
REQ-010 SHALL have port data_valid, input, 1 bit, meaning data_word is offered.
REQ-011 SHALL have port data_word, input, DATA_BITS bits, meaning the word to send.
REQ-012 SHALL have port break_req, input, 1 bit, meaning request line break; present only under UART_TX_FRAMED_BREAK_EN.

Function
REQ-013 SHALL compute DIV = (CLK + BAUD/2) / BAUD, integer, so one bit period equals DIV clocks.
- Example: defaults give DIV = 450.
REQ-014 SHALL fail elaboration if any parameter is outside its legal range or DIV < 2.
REQ-015 SHALL use the states IDLE, START, DATA, PARITY and STOP, plus BREAK under the macro.
REQ-016 SHALL drive data_ready = 1 only in IDLE, registered.
REQ-017 SHALL accept a word on a rising edge E0 where data_ready & data_valid, capturing data_word into a shift register.
REQ-018 SHALL ignore data_word and data_valid whenever data_ready = 0.
REQ-019 SHALL transmit a frame of N = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bits, each exactly DIV clocks, starting at E0.
- Frame order: start bit 0, data bits LSB first, parity bit if enabled, then stop bits 1.
REQ-020 SHALL drive pin from a register.
- pin changes only on bit-period boundaries.
- The first boundary is edge E0.
REQ-021 SHALL set the parity bit so that the total count of ones is odd for PARITY=1 and even for PARITY=2.
- Parity covers the data bits plus the parity bit.
REQ-022 SHALL skip the PARITY state entirely when PARITY=0.
REQ-023 SHALL, in STOP, count STOP_BITS*DIV clocks and return to IDLE at edge E0+N*DIV.
- data_ready = 1 from that edge.
- The earliest next acceptance is at edge E0+N*DIV+1.
REQ-024 SHALL hold pin = 1 continuously in IDLE.
REQ-025 SHALL reload the baud counter to DIV-1 on every bit boundary and decrement it each clock.
- A bit boundary occurs when the counter is 0; there is no free-running wrap.

Reset
REQ-026 SHALL, while reset = 1, force state = IDLE, pin = 1, data_ready = 1, baud counter = 0, bit counter = 0 and shift register = 0.
- This takes effect immediately, independent of clk.
REQ-027 SHALL abort a frame in progress if reset asserts mid-frame.
- pin goes to 1 at once.
- The partial frame is never resumed.
REQ-028 SHALL be able to accept a word on the first rising edge after reset deasserts.

Configuration
REQ-029 SHALL, with UART_TX_FRAMED_BREAK_EN defined, provide port break_req and the BREAK state.
- break_req = 1 in IDLE enters BREAK at the next edge.
- In BREAK: pin = 0 and data_ready = 0 for as long as break_req = 1.
- When break_req deasserts, return to IDLE at the next edge, with pin = 1 and data_ready = 1.
REQ-030 SHALL, with the macro defined, give break_req priority over data_valid in IDLE.
- No word is accepted on that edge.
REQ-031 SHALL, with the macro defined, ignore break_req mid-frame.
- It is sampled only once IDLE is reached again.
REQ-032 SHALL, without UART_TX_FRAMED_BREAK_EN, have no break_req port and no BREAK state.
- Function is otherwise identical.

Verification
REQ-033 Bench SHALL use CLK=8, BAUD=1 (DIV=8), 8N1. Stimulus: send 0x55. Required: pin reads 0,1,0,1,0,1,0,1,0,1 per 8-clock bit, and data_ready returns at E0+80.
REQ-034 Bench SHALL set DATA_BITS=7, PARITY=2, STOP_BITS=2. Stimulus: send 0x41. Required: start, 1000001, parity 0, 11; 11 bits; data_ready at E0+88.
REQ-035 Bench SHALL set PARITY=1. Stimulus: send 0x00. Required: parity bit 1. Stimulus: send 0x01. Required: parity bit 0.
REQ-036 Bench SHALL hold data_valid=1 with 0xA5 then 0x3C. Required: two frames, each accepted only while data_ready=1, with exactly 1 idle-high clock beyond the stop bits between them, and the words unchanged.
REQ-037 Bench SHALL assert reset at clock 30 of a frame. Required: pin=1 and data_ready=1 asynchronously; a new byte 0xFF transmits correctly after release.
REQ-038 Bench SHALL, with UART_TX_FRAMED_BREAK_EN defined, assert break_req and data_valid together in IDLE for 20 clocks. Required: pin=0 for 20 clocks, no byte sent, then data_ready=1 one clock after release.
